regfile_port_arbiter: RTL and testbench

// - Shares the single-port register file between two requesters: req0 (command controller) and req1 (config/debug master).
// - Round-robin grant, one transaction in flight, registered issue to the regfile.
// - Read data is routed back to the owning requester, with a timeout/error response if the regfile never answers.
// - Sits between the requesters and the regfile; owns all regfile wr_en/rd_en/addr/data.

---
 rtl/regfile_arb_pkg.sv | 8 +
 rtl/rf_arb_rr2.sv | 18 +
 rtl/regfile_port_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared state encoding and constants for the regfile port arbiter
package regfile_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} arb_state_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/rf_arb_rr2.sv
// rf_arb_rr2: two-input round-robin grant with a last-grant flop
module rf_arb_rr2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] valid,
    input  logic       grant_en,
    output logic [1:0] gnt
);
    logic last;

    // on contention favour the requester not served last, otherwise pass the lone request
    always_comb gnt = (valid == 2'b11) ? (last ? 2'b01 : 2'b10) : valid;

    // remember who won; reset value makes req0 the first winner under contention
    always_ff @(posedge CLK or negedge RST)
        if (!RST) last <= 1'b1;
        else if (grant_en) last <= gnt[1];
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares a single-port register file between two requesters
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DW     = 8,
    parameter int ADDR_W = 4,
    parameter int TO_CYC = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DW-1:0]     req0_wdata,
    output logic              req0_ready,
    output logic [DW-1:0]     req0_rdata,
    output logic              req0_rdata_valid,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DW-1:0]     req1_wdata,
    output logic              req1_ready,
    output logic [DW-1:0]     req1_rdata,
    output logic              req1_rdata_valid,
    output logic              req1_err,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DW-1:0]     rf_wr_data,
    input  logic [DW-1:0]     rf_rd_data,
    input  logic              rf_rd_valid,
    output logic              busy
);
    localparam int CW = $clog2(TO_CYC + 1);

    arb_state_t        state, state_nx;
    logic [NUM_REQ-1:0] valid, gnt;
    logic              grant_en;
    logic              cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [DW-1:0]     cap_wdata;
    logic              owner;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic [CW-1:0]     cnt;
    logic              timeout;

    assign valid    = {req1_valid, req0_valid};
    assign grant_en = (state == IDLE) && (|valid) && RST;
    assign timeout  = cnt == CW'(TO_CYC);

    rf_arb_rr2 u_rr (
        .CLK      (CLK),
        .RST      (RST),
        .valid    (valid),
        .grant_en (grant_en),
        .gnt      (gnt)
    );

    // state register
    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= IDLE;
        else state <= state_nx;

    // next state and all outputs, decoded from the current state
    always_comb begin
        state_nx         = state;
        busy             = state != IDLE;
        req0_ready       = grant_en & gnt[0];
        req1_ready       = grant_en & gnt[1];
        rf_wr_en         = 1'b0;
        rf_rd_en         = 1'b0;
        rf_addr          = '0;
        rf_wr_data       = '0;
        req0_rdata_valid = 1'b0;
        req0_rdata       = '0;
        req0_err         = 1'b0;
        req1_rdata_valid = 1'b0;
        req1_rdata       = '0;
        req1_err         = 1'b0;
        case (state)
            IDLE: state_nx = grant_en ? ISSUE : IDLE;
            ISSUE: begin
                state_nx   = cap_wr ? IDLE : RD_WAIT;
                rf_wr_en   = cap_wr;
                rf_rd_en   = !cap_wr;
                rf_addr    = cap_addr;
                rf_wr_data = cap_wdata;
            end
            RD_WAIT: state_nx = (rf_rd_valid || timeout) ? RESP : RD_WAIT;
            RESP: begin
                state_nx         = IDLE;
                req0_rdata_valid = !owner;
                req0_rdata       = owner ? '0 : resp_data;
                req0_err         = !owner && resp_err;
                req1_rdata_valid = owner;
                req1_rdata       = owner ? resp_data : '0;
                req1_err         = owner && resp_err;
            end
            default: state_nx = IDLE;
        endcase
    end

    // capture the granted request at the handshake
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            owner     <= 1'b0;
        end else if (grant_en) begin
            cap_wr    <= gnt[1] ? req1_wr    : req0_wr;
            cap_addr  <= gnt[1] ? req1_addr  : req0_addr;
            cap_wdata <= gnt[1] ? req1_wdata : req0_wdata;
            owner     <= gnt[1];
        end

    // read-wait timeout counter and response latch; valid data beats a coincident timeout
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            cnt       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == RD_WAIT) begin
            cnt <= cnt + CW'(1);
            if (rf_rd_valid) begin
                resp_data <= rf_rd_data;
                resp_err  <= 1'b0;
            end else if (timeout) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end
        end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed scenario checks for the regfile port arbiter
module tb_regfile_port_arbiter;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       req0_valid = 0, req0_wr = 0, req1_valid = 0, req1_wr = 0;
    logic [3:0] req0_addr = 0, req1_addr = 0;
    logic [7:0] req0_wdata = 0, req1_wdata = 0;
    logic       req0_ready, req0_rdata_valid, req0_err;
    logic       req1_ready, req1_rdata_valid, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       rf_wr_en, rf_rd_en, rf_rd_valid = 0, busy;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data, rf_rd_data = 0;
    int         total = 0, bad = 0;

    regfile_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rdata(req0_rdata), .req0_rdata_valid(req0_rdata_valid), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rdata(req1_rdata), .req1_rdata_valid(req1_rdata_valid), .req1_err(req1_err),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [38:0] all_out();
        return {req0_ready, req0_rdata, req0_rdata_valid, req0_err, req1_ready, req1_rdata, req1_rdata_valid, req1_err,
                rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, busy};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #2;
        total++; if (all_out() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out()); end
        @(posedge CLK);
        #1 RST = 1'b1;
        tick();
        #1;
        total++; if (all_out() !== '0) begin bad++; $display("FAIL post_reset_idle got=%h exp=0", all_out()); end
    endtask

    task automatic test_write();
        tick();
        req0_valid = 1; req0_wr = 1; req0_addr = 4'h3; req0_wdata = 8'h5A;
        #1;
        total++; if ({req0_ready, req1_ready, busy} !== 3'b100) begin bad++; $display("FAIL wr_ready got=%b exp=100", {req0_ready, req1_ready, busy}); end
        tick();
        req0_valid = 0;
        #1;
        total++; if ({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, busy, req0_ready} !== {2'b10, 4'h3, 8'h5A, 2'b10}) begin
            bad++; $display("FAIL wr_issue got=%b/%b/%h/%h/%b exp=1/0/3/5a/1", rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, busy); end
        tick();
        #1;
        total++; if (all_out() !== '0) begin bad++; $display("FAIL wr_done got=%h exp=0", all_out()); end
    endtask

    task automatic test_read();
        tick();
        req1_valid = 1; req1_wr = 0; req1_addr = 4'h7;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL rd_ready got=%b exp=01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 0;
        #1;
        total++; if ({rf_wr_en, rf_rd_en, rf_addr} !== {2'b01, 4'h7}) begin bad++; $display("FAIL rd_issue got=%b/%b/%h exp=0/1/7", rf_wr_en, rf_rd_en, rf_addr); end
        tick();
        rf_rd_valid = 1; rf_rd_data = 8'hC3;
        #1;
        total++; if ({req1_rdata_valid, rf_rd_en, busy} !== 3'b001) begin bad++; $display("FAIL rd_wait got=%b exp=001", {req1_rdata_valid, rf_rd_en, busy}); end
        tick();
        rf_rd_valid = 0; rf_rd_data = 0;
        #1;
        total++; if ({req1_rdata_valid, req1_rdata, req1_err} !== {1'b1, 8'hC3, 1'b0}) begin
            bad++; $display("FAIL rd_resp got=%b/%h/%b exp=1/c3/0", req1_rdata_valid, req1_rdata, req1_err); end
        total++; if ({req0_ready, req0_rdata, req0_rdata_valid, req0_err} !== '0) begin
            bad++; $display("FAIL rd_other_quiet got=%b/%h/%b/%b exp=0", req0_ready, req0_rdata, req0_rdata_valid, req0_err); end
        tick();
        #1;
        total++; if ({req1_rdata_valid, req1_rdata, busy} !== '0) begin bad++; $display("FAIL rd_done got=%b/%h/%b exp=0", req1_rdata_valid, req1_rdata, busy); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        tick();
        req0_valid = 1; req0_wr = 1; req0_addr = 4'h1; req0_wdata = 8'h11;
        req1_valid = 1; req1_wr = 1; req1_addr = 4'h2; req1_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            total++; if ({req0_ready, req1_ready} !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {req0_ready, req1_ready}, exp_rdy); end
            tick();
            #1;
            total++; if ({rf_wr_en, rf_addr} !== {1'b1, (i % 2 == 0) ? 4'h1 : 4'h2}) begin
                bad++; $display("FAIL rr_issue%0d got=%b/%h exp=1/%0d", i, rf_wr_en, rf_addr, (i % 2 == 0) ? 1 : 2); end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();
        req0_valid = 1; req1_valid = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rr_after_idle got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    task automatic test_timeout();
        int early;
        for (int r = 0; r < 2; r++) begin
            early = 0;
            tick();
            req0_valid = 1; req0_wr = 0; req0_addr = 4'h9;
            #1;
            total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL to_ready%0d got=%b exp=1", r, req0_ready); end
            for (int k = 1; k <= 17; k++) begin
                tick();
                req0_valid = 0;
                rf_rd_valid = (r == 1 && k == 17); rf_rd_data = (r == 1 && k == 17) ? 8'hAA : 8'h00;
                #1;
                if (req0_rdata_valid !== 1'b0 || req1_rdata_valid !== 1'b0) early++;
            end
            total++; if (early !== 0) begin bad++; $display("FAIL to_early%0d got=%0d exp=0", r, early); end
            tick();
            rf_rd_valid = 0; rf_rd_data = 0;
            #1;
            total++; if ({req0_rdata_valid, req0_err, req0_rdata} !== ((r == 0) ? {2'b11, 8'h00} : {2'b10, 8'hAA})) begin
                bad++; $display("FAIL to_resp%0d got=%b/%b/%h exp=%s", r, req0_rdata_valid, req0_err, req0_rdata, (r == 0) ? "1/1/00" : "1/0/aa"); end
            tick();
            #1;
            total++; if ({busy, req0_rdata_valid, req0_err} !== 3'b000) begin bad++; $display("FAIL to_idle%0d got=%b exp=000", r, {busy, req0_rdata_valid, req0_err}); end
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        tick();
        req1_valid = 1; req1_wr = 0; req1_addr = 4'h4;
        tick();
        req1_valid = 0;
        tick();
        #1;
        total++; if ({busy, rf_rd_en} !== 2'b10) begin bad++; $display("FAIL rst_in_wait got=%b exp=10", {busy, rf_rd_en}); end
        RST = 0;
        #1;
        total++; if (all_out() !== '0) begin bad++; $display("FAIL rst_immediate got=%h exp=0", all_out()); end
        tick();
        RST = 1;
        rf_rd_valid = 1; rf_rd_data = 8'h77;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (req0_rdata_valid !== 1'b0 || req1_rdata_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        rf_rd_valid = 0;
        total++; if (stray !== 0) begin bad++; $display("FAIL rst_no_resp got=%0d exp=0", stray); end
        req0_valid = 1; req0_wr = 1; req1_valid = 1; req1_wr = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rst_ptr got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    task automatic test_stray();
        int bad_cyc;
        bad_cyc = 0;
        req0_valid = 1; req0_wr = 1; req0_addr = 4'h5; req0_wdata = 8'h33;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL stray_setup got=%b exp=1", req0_ready); end
        tick();
        req0_valid = 0; req1_valid = 1; req1_wr = 1; req1_addr = 4'hE; rf_rd_valid = 1; rf_rd_data = 8'h99;
        #1;
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL stray_no_ready got=%b exp=0", req1_ready); end
        tick();
        req1_valid = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (all_out() !== '0) bad_cyc++;
            tick();
        end
        rf_rd_valid = 0;
        total++; if (bad_cyc !== 0) begin bad++; $display("FAIL stray_quiet got=%0d exp=0", bad_cyc); end
        req0_valid = 1; req1_valid = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL stray_ptr got=%b exp=01", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
